// File: rtl/ama_riscv_retire_profiler.sv
// Retirement profiler: saturating run statistics plus an optional FWFT trace FIFO.
// Optional trace FIFO enabled by defining PROF_TRACE_FIFO_EN.
module ama_riscv_retire_profiler #(
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ret_valid,
  input  logic [31:0]       ret_inst,
  input  logic [31:0]       ret_pc,
  input  logic              ret_branch_inst,
  input  logic              ret_branch_taken,
  input  logic              ret_bp_hit,
  input  logic [31:0]       ret_dmem_addr,
  input  logic [3:0]        ret_dmem_size,
  input  logic [31:0]       csr_tohost,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [102:0]      trace_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cnt_inst,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_taken,
  output logic [CNT_W-1:0]  cnt_bp_hit,
  output logic [CNT_W-1:0]  cnt_load,
  output logic [CNT_W-1:0]  cnt_store,
  output logic [CNT_W-1:0]  cnt_drop
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_start_acc;
  logic w_capture;
  logic w_clear;
  logic w_fifo_empty;
  logic w_is_load;
  logic w_is_store;
  logic w_is_illegal;

  logic [CNT_W-1:0] r_cnt_inst, r_cnt_branch, r_cnt_taken, r_cnt_bp_hit;
  logic [CNT_W-1:0] r_cnt_load, r_cnt_store;
  logic             r_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  assign w_start_acc  = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_capture    = ret_valid && (r_state == S_RUN);
  assign w_clear      = rst || w_start_acc;
  assign w_is_load    = (ret_dmem_size < 4'd4);
  assign w_is_store   = (ret_dmem_size[3:2] == 2'b01);
  assign w_is_illegal = (ret_dmem_size > 4'd8);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (csr_tohost != 32'd0) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_fifo_empty) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_cnt_inst   <= '0;
      r_cnt_branch <= '0;
      r_cnt_taken  <= '0;
      r_cnt_bp_hit <= '0;
      r_cnt_load   <= '0;
      r_cnt_store  <= '0;
      r_err        <= 1'b0;
    end else if (w_capture) begin
      r_cnt_inst   <= sat_inc(r_cnt_inst, 1'b1);
      r_cnt_branch <= sat_inc(r_cnt_branch, ret_branch_inst);
      r_cnt_taken  <= sat_inc(r_cnt_taken, ret_branch_inst && ret_branch_taken);
      r_cnt_bp_hit <= sat_inc(r_cnt_bp_hit, ret_branch_inst && ret_bp_hit);
      r_cnt_load   <= sat_inc(r_cnt_load, w_is_load);
      r_cnt_store  <= sat_inc(r_cnt_store, w_is_store);
      if (w_is_illegal) r_err <= 1'b1;
    end
  end

  assign cnt_inst   = r_cnt_inst;
  assign cnt_branch = r_cnt_branch;
  assign cnt_taken  = r_cnt_taken;
  assign cnt_bp_hit = r_cnt_bp_hit;
  assign cnt_load   = r_cnt_load;
  assign cnt_store  = r_cnt_store;
  assign err        = r_err;

`ifdef PROF_TRACE_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [102:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_cnt_drop;
  logic [102:0]     w_record;
  logic             w_full, w_push, w_pop, w_drop;

  assign w_record = {ret_pc, ret_inst, ret_dmem_addr, ret_dmem_size,
                     ret_branch_inst, ret_branch_taken, ret_bp_hit};
  assign w_fifo_empty = (r_count == '0);
  assign w_full       = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_pop        = trace_valid && trace_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign w_push       = w_capture && (!w_full || w_pop);
  assign w_drop       = w_capture && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_cnt_drop <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_cnt_drop <= sat_inc(r_cnt_drop, w_drop);
    end
  end

  // NOTE: storage is not reset; validity comes solely from r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_record;
  end

  assign trace_valid = !w_fifo_empty;
  assign trace_data  = trace_valid ? r_mem[r_rptr] : '0;
  assign cnt_drop    = r_cnt_drop;
`else
  logic w_unused;

  assign w_unused     = ^{trace_ready, ret_inst, ret_pc, ret_dmem_addr};
  assign w_fifo_empty = 1'b1;
  assign trace_valid  = 1'b0;
  assign trace_data   = '0;
  assign cnt_drop     = '0;
`endif

endmodule
